// File: rtl/doorbell_pkg.sv
// Shared defaults and helpers for the doorbell dispatcher.
//   DEF_NUM_ENG / DEF_DATA_W / DEF_FIFO_DEPTH : default parameter values
//   eng_mask_t                                : per-engine bit mask at default width
//   rr_first_free()                           : round-robin first-free engine search
package doorbell_pkg;

    localparam int unsigned DEF_NUM_ENG    = 4;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned MAX_ENG        = 16;

    typedef logic [DEF_NUM_ENG-1:0] eng_mask_t;

    // Scan ptr, ptr+1, ... mod n and return the first index whose free bit is set.
    // The mask is zero-extended to MAX_ENG so one function serves every NUM_ENG.
    function automatic logic [3:0] rr_first_free(
        input logic [MAX_ENG-1:0] free_mask,
        input logic [3:0]         ptr,
        input int unsigned        n
    );
        logic [3:0]  idx;
        logic        found;
        int unsigned j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_ENG; k++) begin
            if (k < n && !found) begin
                j = (32'(ptr) + k) % n;
                if (free_mask[j[3:0]]) begin
                    idx   = j[3:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/doorbell_dispatcher_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
//   clk, rstn       : clock, asynchronous active-low reset
//   i_push, i_data  : write strobe and payload (caller guarantees not full)
//   i_pop           : read strobe (caller guarantees not empty)
//   o_data          : head entry, valid while not empty
//   o_full, o_empty : status
//   o_count         : number of stored entries
module cmd_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                i_push,
    input  logic [DATA_W-1:0]                   i_data,
    input  logic                                i_pop,
    output logic [DATA_W-1:0]                   o_data,
    output logic                                o_full,
    output logic                                o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/doorbell_dispatcher.sv
// Doorbell dispatcher: queues commands and rings free engines round-robin.
//   clk, rstn                     : clock, asynchronous active-low reset
//   cmd_valid_in, cmd_data_in     : command offer
//   cmd_ready_out                 : FIFO has room
//   set_out, cmd_data_out         : one-cycle one-hot set pulse plus payload
//   done_in                       : per-engine completion pulses
//   busy_out                      : per-engine busy flags
//   fifo_count_out                : FIFO occupancy
//   idle_out                      : nothing queued and no engine busy
module doorbell_dispatcher
    import doorbell_pkg::*;
#(
    parameter int unsigned NUM_ENG    = DEF_NUM_ENG,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                cmd_valid_in,
    input  logic [DATA_W-1:0]                   cmd_data_in,
    output logic                                cmd_ready_out,
    output logic [NUM_ENG-1:0]                  set_out,
    output logic [DATA_W-1:0]                   cmd_data_out,
    input  logic [NUM_ENG-1:0]                  done_in,
    output logic [NUM_ENG-1:0]                  busy_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count_out,
    output logic                                idle_out
);

    localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_ENG-1:0] r_busy;
    logic [NUM_ENG-1:0] r_set;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_rr;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_head;
    logic [CNT_W-1:0]   w_count;
    logic [NUM_ENG-1:0] w_free;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_rr_next;
    logic [NUM_ENG-1:0] w_onehot;

    cmd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (cmd_data_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Dispatch decision: head waiting and at least one engine free.
    always_comb begin
        w_free    = ~r_busy;
        w_push    = cmd_valid_in & ~w_full;
        w_pop     = ~w_empty & (|w_free);
        w_sel     = IDX_W'(rr_first_free(MAX_ENG'(w_free), 4'(r_rr), NUM_ENG));
        w_onehot  = NUM_ENG'(1) << w_sel;
        w_rr_next = (w_sel == IDX_W'(NUM_ENG - 1)) ? '0 : w_sel + IDX_W'(1);
    end

    // Set/clear never collide on one engine: set targets free, clear targets busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
            r_set  <= '0;
            r_data <= '0;
            r_rr   <= '0;
        end else begin
            r_busy <= (r_busy & ~done_in) | (w_pop ? w_onehot : '0);
            r_set  <= w_pop ? w_onehot : '0;
            if (w_pop) begin
                r_data <= w_head;
                r_rr   <= w_rr_next;
            end
        end
    end

    assign cmd_ready_out  = ~w_full;
    assign set_out        = r_set;
    assign cmd_data_out   = r_data;
    assign busy_out       = r_busy;
    assign fifo_count_out = w_count;
    assign idle_out       = w_empty & ~(|r_busy);

endmodule

// File: tb/tb_doorbell_dispatcher.sv
module tb_doorbell_dispatcher;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        cmd_valid_in;
    logic [31:0] cmd_data_in;
    logic        cmd_ready_out;
    logic [3:0]  set_out;
    logic [31:0] cmd_data_out;
    logic [3:0]  done_in;
    logic [3:0]  busy_out;
    logic [2:0]  fifo_count_out;
    logic        idle_out;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    doorbell_dispatcher #(
        .NUM_ENG    (4),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_data_in    (cmd_data_in),
        .cmd_ready_out  (cmd_ready_out),
        .set_out        (set_out),
        .cmd_data_out   (cmd_data_out),
        .done_in        (done_in),
        .busy_out       (busy_out),
        .fifo_count_out (fifo_count_out),
        .idle_out       (idle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every set pulse must match the next expected dispatch.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && set_out !== 4'b0000) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: set_out=%b data=%h, no dispatch expected", set_out, cmd_data_out);
            end else begin
                e = sb.pop_front();
                if (set_out !== e.mask || cmd_data_out !== e.data)
                    $display("FAIL dispatch: got set=%b data=%h, want set=%b data=%h", set_out, cmd_data_out, e.mask, e.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid_in = 1'b0;
        cmd_data_in  = '0;
        done_in      = '0;
        rstn         = 1'b0;
        sb.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({set_out, cmd_data_out, busy_out, fifo_count_out, cmd_ready_out, idle_out} !==
            {4'b0000, 32'h0, 4'b0000, 3'd0, 1'b1, 1'b1})
            $display("FAIL reset_values: set=%b data=%h busy=%b cnt=%0d rdy=%b idle=%b, want 0/0/0/0/1/1",
                     set_out, cmd_data_out, busy_out, fifo_count_out, cmd_ready_out, idle_out);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        sb.push_back('{mask: 4'b0001, data: 32'hA5});
        cmd_valid_in = 1'b1; cmd_data_in = 32'hA5;
        tick();
        cmd_valid_in = 1'b0;
        n_total++;
        if (fifo_count_out !== 3'd1 || set_out !== 4'b0000)
            $display("FAIL single_queued: cnt=%0d set=%b, want 1 / 0000", fifo_count_out, set_out);
        else n_pass++;
        tick();
        n_total++;
        if (set_out !== 4'b0001 || busy_out !== 4'b0001 || fifo_count_out !== 3'd0 || idle_out !== 1'b0)
            $display("FAIL single_dispatch: set=%b busy=%b cnt=%0d idle=%b, want 0001/0001/0/0",
                     set_out, busy_out, fifo_count_out, idle_out);
        else n_pass++;
        tick();
        n_total++;
        if (set_out !== 4'b0000 || cmd_data_out !== 32'hA5)
            $display("FAIL single_pulse_width: set=%b data=%h, want 0000 / a5 held", set_out, cmd_data_out);
        else n_pass++;
        done_in = 4'b0001;
        tick();
        done_in = 4'b0000;
        n_total++;
        if (busy_out !== 4'b0000 || idle_out !== 1'b1)
            $display("FAIL single_done: busy=%b idle=%b, want 0000 / 1", busy_out, idle_out);
        else n_pass++;
        // rr pointer advanced to 1, so engine 1 wins although engine 0 is free
        sb.push_back('{mask: 4'b0010, data: 32'hB7});
        cmd_valid_in = 1'b1; cmd_data_in = 32'hB7;
        tick();
        cmd_valid_in = 1'b0;
        tick();
        tick();
        n_total++;
        if (busy_out !== 4'b0010 || sb.size() != 0)
            $display("FAIL single_rr_ptr: busy=%b pending=%0d, want 0010 / 0", busy_out, sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++)
            sb.push_back('{mask: 4'(1 << i), data: 32'(i + 1)});
        for (int i = 1; i <= 5; i++) begin
            cmd_valid_in = 1'b1; cmd_data_in = 32'(i);
            tick();
        end
        cmd_valid_in = 1'b0;
        tick(); tick(); tick();
        n_total++;
        if (fifo_count_out !== 3'd1 || busy_out !== 4'b1111 || idle_out !== 1'b0 || cmd_ready_out !== 1'b1)
            $display("FAIL b2b_state: cnt=%0d busy=%b idle=%b rdy=%b, want 1/1111/0/1",
                     fifo_count_out, busy_out, idle_out, cmd_ready_out);
        else n_pass++;
        n_total++;
        if (sb.size() != 0)
            $display("FAIL b2b_all_dispatched: pending=%0d, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_done_redispatch();
        sb.push_back('{mask: 4'b0100, data: 32'd5});
        done_in = 4'b0100;
        tick();
        done_in = 4'b0000;
        n_total++;
        if (busy_out !== 4'b1011 || set_out !== 4'b0000 || fifo_count_out !== 3'd1)
            $display("FAIL done_clear: busy=%b set=%b cnt=%0d, want 1011/0000/1", busy_out, set_out, fifo_count_out);
        else n_pass++;
        tick();
        n_total++;
        if (set_out !== 4'b0100 || busy_out !== 4'b1111 || fifo_count_out !== 3'd0 || idle_out !== 1'b0)
            $display("FAIL done_redispatch: set=%b busy=%b cnt=%0d idle=%b, want 0100/1111/0/0",
                     set_out, busy_out, fifo_count_out, idle_out);
        else n_pass++;
        tick();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL done_pending: pending=%0d, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            cmd_valid_in = 1'b1; cmd_data_in = 32'h10 + 32'(i);
            tick();
        end
        cmd_data_in = 32'h14;
        tick(); tick();
        n_total++;
        if (fifo_count_out !== 3'd4 || cmd_ready_out !== 1'b0)
            $display("FAIL full_hold: cnt=%0d rdy=%b, want 4 / 0", fifo_count_out, cmd_ready_out);
        else n_pass++;
        sb.push_back('{mask: 4'b0001, data: 32'h10});
        done_in = 4'b0001;
        tick();
        done_in = 4'b0000;
        n_total++;
        if (busy_out !== 4'b1110 || fifo_count_out !== 3'd4 || cmd_ready_out !== 1'b0)
            $display("FAIL full_done: busy=%b cnt=%0d rdy=%b, want 1110/4/0", busy_out, fifo_count_out, cmd_ready_out);
        else n_pass++;
        tick();
        n_total++;
        if (busy_out !== 4'b1111 || fifo_count_out !== 3'd3 || cmd_ready_out !== 1'b1)
            $display("FAIL full_pop: busy=%b cnt=%0d rdy=%b, want 1111/3/1", busy_out, fifo_count_out, cmd_ready_out);
        else n_pass++;
        tick();
        cmd_valid_in = 1'b0;
        n_total++;
        if (fifo_count_out !== 3'd4 || cmd_ready_out !== 1'b0)
            $display("FAIL full_refill: cnt=%0d rdy=%b, want 4 / 0", fifo_count_out, cmd_ready_out);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (sb.size() != 0 || fifo_count_out !== 3'd4)
            $display("FAIL full_settle: pending=%0d cnt=%0d, want 0 / 4", sb.size(), fifo_count_out);
        else n_pass++;
    endtask

    task automatic test_done_idle();
        do_reset();
        done_in = 4'b0010;
        tick();
        done_in = 4'b0000;
        n_total++;
        if (busy_out !== 4'b0000 || idle_out !== 1'b1 || fifo_count_out !== 3'd0 || set_out !== 4'b0000)
            $display("FAIL done_on_idle: busy=%b idle=%b cnt=%0d set=%b, want 0000/1/0/0000",
                     busy_out, idle_out, fifo_count_out, set_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++)
            sb.push_back('{mask: 4'(1 << i), data: 32'h20 + 32'(i)});
        for (int i = 0; i < 7; i++) begin
            cmd_valid_in = 1'b1; cmd_data_in = 32'h20 + 32'(i);
            tick();
        end
        cmd_valid_in = 1'b0;
        done_in = 4'b0100;
        tick();
        done_in = 4'b0000;
        n_total++;
        if (busy_out !== 4'b1011 || fifo_count_out !== 3'd3)
            $display("FAIL midrst_setup: busy=%b cnt=%0d, want 1011 / 3", busy_out, fifo_count_out);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++;
        if ({set_out, cmd_data_out, busy_out, fifo_count_out, cmd_ready_out, idle_out} !==
            {4'b0000, 32'h0, 4'b0000, 3'd0, 1'b1, 1'b1})
            $display("FAIL midrst_async: set=%b data=%h busy=%b cnt=%0d rdy=%b idle=%b, want 0/0/0/0/1/1",
                     set_out, cmd_data_out, busy_out, fifo_count_out, cmd_ready_out, idle_out);
        else n_pass++;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_total++;
        if (busy_out !== 4'b0000 || fifo_count_out !== 3'd0 || idle_out !== 1'b1 || sb.size() != 0)
            $display("FAIL midrst_quiet: busy=%b cnt=%0d idle=%b pending=%0d, want 0000/0/1/0",
                     busy_out, fifo_count_out, idle_out, sb.size());
        else n_pass++;
        sb.push_back('{mask: 4'b0001, data: 32'h77});
        cmd_valid_in = 1'b1; cmd_data_in = 32'h77;
        tick();
        cmd_valid_in = 1'b0;
        tick(); tick();
        n_total++;
        if (busy_out !== 4'b0001 || sb.size() != 0)
            $display("FAIL midrst_new_cmd: busy=%b pending=%0d, want 0001 / 0", busy_out, sb.size());
        else n_pass++;
    endtask

    initial begin
        rstn         = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_data_in  = '0;
        done_in      = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_done_redispatch();
        test_full();
        test_done_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
